// File: rtl/noc_pkg.sv
// noc_pkg: flit-type constants, generator FSM states and head-flit packing shared by the NoC blocks.
package noc_pkg;
  localparam logic [1:0] HEAD_FLIT = 2'b01;
  localparam logic [1:0] HEADER    = 2'b11;
  localparam logic [1:0] BODY_FLIT = 2'b10;
  localparam logic [1:0] TAIL_FLIT = 2'b00;
  localparam int HEAD_TAIL = 2;
  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL, S_GAP, S_DONE} state_e;
  function automatic int dest_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int vc_w(input int v);
    return $clog2(v);
  endfunction
  // {vc, dest, src, pkt_id}; pkt_id is cut to whatever width is left over
  function automatic logic [63:0] pack_head(input logic [63:0] vc, dest, src, id, input int dw, iw);
    logic [63:0] m;
    m = (64'd1 << iw) - 64'd1;
    return (vc << (2 * dw + iw)) | (dest << (dw + iw)) | (src << iw) | (id & m);
  endfunction
endpackage

// File: rtl/noc_traffic_gen_dest_sel.sv
// noc_dest_sel: per-packet destination select with a rotating pointer that skips this node.
module noc_dest_sel
  import noc_pkg::*;
#(
  parameter int NUM_OF_NODES = 8,
  parameter int NODE_ID = 0,
  parameter int DW = dest_w(NUM_OF_NODES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode_i,
  input  logic [DW-1:0] fixed_dest_i,
  input  logic          advance_i,
  output logic [DW-1:0] dest_o
);
  logic [DW-1:0] rot_q, rot_d, inc;
  always_comb begin
    inc = rot_q + DW'(1);
    rot_d = (advance_i && mode_i == 2'd3) ? (inc == DW'(NODE_ID) ? inc + DW'(1) : inc) : rot_q;
    dest_o = mode_i == 2'd0 ? fixed_dest_i :
             mode_i == 2'd1 ? DW'(NODE_ID + NUM_OF_NODES - 1) :
             mode_i == 2'd2 ? DW'(NODE_ID + NUM_OF_NODES / 2) : rot_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rot_q <= DW'(NODE_ID + 1);
    else rot_q <= rot_d;
  end
endmodule

// File: rtl/noc_traffic_gen.sv
// noc_traffic_gen: runtime-configurable packet injector for one spidergon node.
module noc_traffic_gen
  import noc_pkg::*;
#(
  parameter int NUM_OF_NODES = 8,
  parameter int FLIT_DATA_WIDTH = 16,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int NODE_ID = 0,
  parameter int MAX_PKT_LEN = 16,
  parameter int CNT_WIDTH = 16,
  parameter int DW = dest_w(NUM_OF_NODES),
  parameter int VW = vc_w(NUM_OF_VIRTUAL_CHANNELS),
  parameter int LEN_W = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 dest_mode,
  input  logic [DW-1:0]              fixed_dest,
  input  logic                       vc_mode,
  input  logic [VW-1:0]              fixed_vc,
  input  logic [LEN_W-1:0]           pkt_len,
  input  logic [CNT_WIDTH-1:0]       num_pkts,
  input  logic [7:0]                 gap_cycles,
  output logic [FLIT_DATA_WIDTH+1:0] flit_out,
  output logic                       flit_valid,
  input  logic                       flit_ready,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       pkts_sent,
  output logic [CNT_WIDTH-1:0]       flits_sent
);
  localparam int IW = FLIT_DATA_WIDTH - VW - 2 * DW;
  state_e state_q, state_d, end_st;
  logic [1:0] dmode_q, ftype;
  logic [DW-1:0] fdest_q, dest;
  logic vmode_q, go, acc, pkt_end;
  logic [VW-1:0] fvc_q, rr_q, vc;
  logic [LEN_W-1:0] len_q, idx_q, idx_d;
  logic [CNT_WIDTH-1:0] num_q, pkts_q, pkts_d, flits_q, flits_d, pkts_inc;
  logic [7:0] gcfg_q, gap_q, gap_d;
  logic [FLIT_DATA_WIDTH-1:0] payload;
  noc_dest_sel #(.NUM_OF_NODES(NUM_OF_NODES), .NODE_ID(NODE_ID), .DW(DW)) u_dest (
    .clk(clk), .reset(reset), .mode_i(dmode_q), .fixed_dest_i(fdest_q),
    .advance_i(pkt_end), .dest_o(dest)
  );
  always_comb begin
    go = start && (state_q == S_IDLE || state_q == S_DONE);
    acc = flit_valid && flit_ready;
    pkt_end = acc && (state_q == S_TAIL || (state_q == S_HEAD && len_q == LEN_W'(1)));
    pkts_inc = &pkts_q ? pkts_q : pkts_q + CNT_WIDTH'(1);
    end_st = pkts_inc == num_q ? S_DONE : gcfg_q != 8'd0 ? S_GAP : S_HEAD;
    pkts_d = go ? '0 : pkt_end ? pkts_inc : pkts_q;
    flits_d = go ? '0 : (acc && !(&flits_q)) ? flits_q + CNT_WIDTH'(1) : flits_q;
    state_d = state_q;
    idx_d = idx_q;
    gap_d = gap_q;
    case (state_q)
      S_IDLE, S_DONE: if (go) state_d = num_pkts != '0 ? S_HEAD : S_DONE;
      S_HEAD: if (acc) begin
        idx_d = LEN_W'(1);
        state_d = len_q == LEN_W'(1) ? end_st : len_q == LEN_W'(HEAD_TAIL) ? S_TAIL : S_BODY;
      end
      S_BODY: if (acc) begin
        idx_d = idx_q + LEN_W'(1);
        if (idx_q == len_q - LEN_W'(2)) state_d = S_TAIL;
      end
      S_TAIL: if (acc) state_d = end_st;
      S_GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd0) state_d = S_HEAD;
      end
      default: state_d = S_IDLE;
    endcase
    // GAP runs gap_cycles cycles, counting down to zero
    if (pkt_end) gap_d = gcfg_q - 8'd1;
  end
  always_comb begin
    vc = vmode_q ? rr_q : fvc_q;
    flit_valid = state_q == S_HEAD || state_q == S_BODY || state_q == S_TAIL;
    ftype = state_q == S_HEAD ? (len_q == LEN_W'(1) ? HEADER : HEAD_FLIT) :
            state_q == S_BODY ? BODY_FLIT : TAIL_FLIT;
    payload = state_q == S_HEAD ?
      FLIT_DATA_WIDTH'(pack_head(64'(vc), 64'(dest), 64'(NODE_ID), 64'(pkts_q), DW, IW)) :
      FLIT_DATA_WIDTH'({8'(pkts_q), (FLIT_DATA_WIDTH - 8)'(idx_q)});
    flit_out = flit_valid ? {ftype, payload} : '0;
    busy = flit_valid || state_q == S_GAP;
    done = state_q == S_DONE;
    pkts_sent = pkts_q;
    flits_sent = flits_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      gap_q <= '0;
      pkts_q <= '0;
      flits_q <= '0;
      rr_q <= '0;
      dmode_q <= '0;
      fdest_q <= '0;
      vmode_q <= 1'b0;
      fvc_q <= '0;
      len_q <= LEN_W'(1);
      num_q <= '0;
      gcfg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      pkts_q <= pkts_d;
      flits_q <= flits_d;
      if (pkt_end && vmode_q) rr_q <= rr_q + VW'(1);
      if (go) begin
        dmode_q <= dest_mode;
        fdest_q <= fixed_dest;
        vmode_q <= vc_mode;
        fvc_q <= fixed_vc;
        len_q <= pkt_len == '0 ? LEN_W'(1) : pkt_len > LEN_W'(MAX_PKT_LEN) ? LEN_W'(MAX_PKT_LEN) : pkt_len;
        num_q <= num_pkts;
        gcfg_q <= gap_cycles;
      end
    end
  end
endmodule

// File: tb/tb_noc_traffic_gen.sv
// tb_noc_traffic_gen: table-driven, directed and randomized checks of the traffic generator against a packet-list model.
module tb_noc_traffic_gen;
  localparam int N = 8, ID = 1;
  typedef struct { int dmode; int fdest; int vmode; int fvc; int len; int num; int gap; } cfg_t;
  typedef struct { cfg_t c; logic [17:0] first; int flits; int pkts; } vec_t;
  logic clk = 0, reset = 1, start = 0, vc_mode = 0, flit_ready = 0;
  logic [1:0] dest_mode = 0;
  logic [2:0] fixed_dest = 0;
  logic [0:0] fixed_vc = 0;
  logic [4:0] pkt_len = 0;
  logic [15:0] num_pkts = 0;
  logic [7:0] gap_cycles = 0;
  logic [17:0] flit_out;
  logic flit_valid, busy, done;
  logic [15:0] pkts_sent, flits_sent;
  int vecs = 0, fails = 0, m_rot = ID + 1, m_rr = 0, vlow, end_cyc;
  logic [17:0] got[$], exp_q[$];
  int acc_cyc[$];
  vec_t tbl[6];
  always #5 clk = ~clk;
  noc_traffic_gen #(.NUM_OF_NODES(N), .FLIT_DATA_WIDTH(16), .NUM_OF_VIRTUAL_CHANNELS(2),
                    .NODE_ID(ID), .MAX_PKT_LEN(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dest_mode(dest_mode), .fixed_dest(fixed_dest),
    .vc_mode(vc_mode), .fixed_vc(fixed_vc), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .gap_cycles(gap_cycles), .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .busy(busy), .done(done), .pkts_sent(pkts_sent), .flits_sent(flits_sent));

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    m_rot = ID + 1;
    m_rr = 0;
  endtask

  // expected flit list of a whole run, straight from the packet format rules
  task automatic model(input cfg_t c);
    int l, d, v;
    exp_q.delete();
    l = c.len == 0 ? 1 : c.len > 16 ? 16 : c.len;
    for (int p = 0; p < c.num; p++) begin
      d = c.dmode == 0 ? c.fdest : c.dmode == 1 ? (ID + N - 1) % N : c.dmode == 2 ? (ID + N / 2) % N : m_rot;
      v = c.vmode ? m_rr : c.fvc;
      exp_q.push_back({(l == 1 ? 2'b11 : 2'b01), 16'(v * 32768 + d * 4096 + ID * 512 + p % 512)});
      for (int i = 1; i < l - 1; i++) exp_q.push_back({2'b10, 8'(p), 8'(i)});
      if (l > 1) exp_q.push_back({2'b00, 8'(p), 8'(l - 1)});
      if (c.vmode) m_rr = (m_rr + 1) % 2;
      if (c.dmode == 3) begin
        m_rot = (m_rot + 1) % N;
        if (m_rot == ID) m_rot = (m_rot + 1) % N;
      end
    end
  endtask

  task automatic start_pulse(input cfg_t c);
    @(negedge clk);
    dest_mode = 2'(c.dmode); fixed_dest = 3'(c.fdest); vc_mode = c.vmode[0]; fixed_vc = 1'(c.fvc);
    pkt_len = 5'(c.len); num_pkts = 16'(c.num); gap_cycles = 8'(c.gap);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run(input cfg_t c, input int pct, input bit stall);
    logic [17:0] prev;
    bit pend;
    start_pulse(c);
    got.delete(); acc_cyc.delete();
    vlow = 0; end_cyc = -1; pend = 0; prev = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      flit_ready = stall ? !(cyc >= 1 && cyc <= 3) : ($urandom_range(99) < pct);
      #1;
      if (done) begin
        end_cyc = cyc;
        break;
      end
      if (pend) begin
        chk("hold_valid", 64'(flit_valid), 64'd1);
        chk("hold_flit", 64'(flit_out), 64'(prev));
      end
      if (!flit_valid) vlow++;
      if (flit_valid && flit_ready) begin
        got.push_back(flit_out);
        acc_cyc.push_back(cyc);
      end
      pend = flit_valid && !flit_ready;
      prev = flit_out;
      @(negedge clk);
    end
    if (end_cyc < 0) begin
      vecs++; fails++;
      $display("FAIL timeout: done not seen, got %0d flits expected %0d", got.size(), exp_q.size());
    end
    flit_ready = 0;
  endtask

  task automatic check_run(input cfg_t c);
    chk("flit_count", 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk($sformatf("flit[%0d]", i), 64'(got[i]), 64'(exp_q[i]));
    chk("flits_sent", 64'(flits_sent), 64'(exp_q.size()));
    chk("pkts_sent", 64'(pkts_sent), 64'(c.num));
    chk("done", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    cfg_t c;
    int dests[9] = '{2, 3, 4, 5, 6, 7, 0, 2, 3};
    tbl[0] = '{'{1, 0, 0, 0, 1, 1, 0}, 18'h30200, 1, 1};
    tbl[1] = '{'{2, 0, 0, 0, 4, 2, 0}, 18'h15200, 8, 2};
    tbl[2] = '{'{0, 1, 0, 1, 3, 1, 0}, 18'h19200, 3, 1};
    tbl[3] = '{'{0, 7, 0, 0, 0, 2, 0}, 18'h37200, 2, 2};
    tbl[4] = '{'{1, 0, 0, 0, 31, 1, 0}, 18'h10200, 16, 1};
    tbl[5] = '{'{3, 0, 0, 0, 2, 0, 1}, 18'h00000, 0, 0};
    #2;
    chk("rst_valid", 64'(flit_valid), 64'd0);
    chk("rst_flit", 64'(flit_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pkts", 64'(pkts_sent), 64'd0);
    chk("rst_flits", 64'(flits_sent), 64'd0);
    do_reset();
    foreach (tbl[k]) begin
      do_reset();
      model(tbl[k].c);
      run(tbl[k].c, 100, 0);
      check_run(tbl[k].c);
      if (tbl[k].flits > 0) chk($sformatf("tbl%0d_first", k), 64'(got[0]), 64'(tbl[k].first));
      chk($sformatf("tbl%0d_flits", k), 64'(flits_sent), 64'(tbl[k].flits));
      chk($sformatf("tbl%0d_pkts", k), 64'(pkts_sent), 64'(tbl[k].pkts));
      if (k == 0) chk("single_done_cycle", 64'(end_cyc), 64'd1);
      if (k == 5) chk("zero_pkts_done_cycle", 64'(end_cyc), 64'd0);
    end
    do_reset();
    c = tbl[1].c;
    model(c);
    run(c, 100, 0);
    check_run(c);
    chk("b2b_span", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
    chk("b2b_dest0", 64'(got[0][14:12]), 64'd5);
    chk("b2b_dest1", 64'(got[4][14:12]), 64'd5);
    do_reset();
    model(c);
    run(c, 100, 1);
    check_run(c);
    chk("stall_accept_cycle", 64'(acc_cyc[1]), 64'd4);
    do_reset();
    c = '{3, 0, 1, 0, 2, 9, 0};
    model(c);
    run(c, 100, 0);
    check_run(c);
    for (int p = 0; p < 9; p++) begin
      chk($sformatf("rot_dest%0d", p), 64'(got[2 * p][14:12]), 64'(dests[p]));
      chk($sformatf("rr_vc%0d", p), 64'(got[2 * p][15]), 64'(p % 2));
    end
    do_reset();
    c = '{0, 3, 0, 0, 2, 2, 3};
    model(c);
    run(c, 100, 0);
    check_run(c);
    chk("gap_low_cycles", 64'(vlow), 64'd3);
    chk("gap_span", 64'(acc_cyc[2] - acc_cyc[1]), 64'd4);
    do_reset();
    start_pulse('{0, 2, 0, 0, 6, 1, 0});
    flit_ready = 1;
    repeat (2) @(negedge clk);
    chk("mid_body_type", 64'(flit_out[17:16]), 64'd2);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("async_valid", 64'(flit_valid), 64'd0);
    chk("async_flits", 64'(flits_sent), 64'd0);
    chk("async_pkts", 64'(pkts_sent), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 0;
    flit_ready = 0;
    m_rot = ID + 1;
    m_rr = 0;
    for (int r = 0; r < 25; r++) begin
      c = '{int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(1)), int'($urandom_range(1)),
            int'($urandom_range(18)), int'($urandom_range(4)), int'($urandom_range(3))};
      model(c);
      run(c, int'($urandom_range(100, 40)), 0);
      check_run(c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
